isp_ae_response_gen: RTL and testbench

- Auto-exposure decision engine that accumulates luma statistics over each active frame.
- At frame end, compares the frame mean against two thresholds and issues a 2-bit ae_response code plus a one-cycle valid strobe.
- Producer side of the ae_response interface consumed by the digital-gain index updater: 01 = decrement gain index, 11 = increment, 00/10 = hold.
- Sits after demosaic/CSC on the luma path, in the statistics branch parallel to the main pipeline.

---
 rtl/isp_ae_response_gen.sv | 165 ++++++++++++++++
 tb/tb_isp_ae_response_gen.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/isp_ae_response_gen.sv
// isp_ae_response_gen: auto-exposure decision engine on the luma statistics
// branch. Accumulates luma over each active frame and, three pclk edges
// after frame end, emits a 2-bit gain-steering code with a one-cycle strobe.
//   01 = over (decrement gain), 11 = under (increment), 10 = no data, 00 = ok.
// Optional macro ISP_AE_HYST_EN: 01/11 only pass when two consecutive
// evaluated frames agree; otherwise 00 is issued.
module isp_ae_response_gen #(
  parameter int BITS     = 8,
  parameter int WIDTH    = 1920,
  parameter int HEIGHT   = 1080,
  parameter int LOW_TH   = 64,
  parameter int HIGH_TH  = 192,
  parameter int SKIP     = 0,
  parameter int CNT_BITS = $clog2(WIDTH*HEIGHT+1),
  parameter int SUM_BITS = BITS+CNT_BITS
) (
  input  logic            pclk,
  input  logic            rst,
  input  logic            enable,
  input  logic            in_vsync,
  input  logic            in_href,
  input  logic [BITS-1:0] in_data,
  output logic [1:0]      ae_response,
  output logic            ae_valid
);

  localparam int FC_BITS = (SKIP > 0) ? $clog2(SKIP+1) : 1;
  localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
  localparam logic [CNT_BITS-1:0] CNT_NEAR = CNT_MAX - 1'b1;
  localparam logic [FC_BITS-1:0]  FC_LAST  = FC_BITS'(SKIP);

  typedef enum logic [1:0] {IDLE, ACCUM, EVAL, CMP} state_t;

  state_t              state, state_n;
  logic                vs_d, armed, rise, fall, pix_vld;
  logic [SUM_BITS-1:0] sum, snap_sum, lo, hi;
  logic [CNT_BITS-1:0] cnt, snap_cnt;
  logic                ovf, snap_ovf, snap_skip;
  logic [FC_BITS-1:0]  fcnt;
  logic [1:0]          raw, dec, dec_q;
  logic                dec_vld;

  // vsync edge tracking; armed blocks a false rise when reset releases mid-frame
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      vs_d  <= 1'b0;
      armed <= 1'b0;
    end else begin
      vs_d  <= in_vsync;
      armed <= armed | ~in_vsync;
    end
  end

  assign rise    = in_vsync & ~vs_d & armed;
  assign fall    = ~in_vsync & vs_d;
  assign pix_vld = (state == ACCUM) & in_vsync & in_href;

  // state register
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // next-state: disable always parks in IDLE, re-arm only on a fresh vsync rise
  always_comb begin
    state_n = state;
    if (!enable) state_n = IDLE;
    else begin
      case (state)
        IDLE:    if (rise) state_n = ACCUM;
        ACCUM:   if (fall) state_n = EVAL;
        EVAL:    state_n = CMP;
        CMP:     state_n = rise ? ACCUM : IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // live accumulation, frame-end snapshot and frame-skip counter
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      sum <= '0; cnt <= '0; ovf <= 1'b0;
      snap_sum <= '0; snap_cnt <= '0; snap_ovf <= 1'b0; snap_skip <= 1'b0;
      fcnt <= '0;
    end else begin
      if (enable && state == ACCUM && fall) begin
        snap_sum  <= sum;
        snap_cnt  <= cnt;
        snap_ovf  <= ovf;
        snap_skip <= (fcnt != '0);
        fcnt      <= (fcnt == FC_LAST) ? '0 : fcnt + 1'b1;
      end
      if (!enable || rise || fall) begin
        sum <= '0; cnt <= '0; ovf <= 1'b0;
      end else if (pix_vld) begin
        // saturate: once count hits all-ones the frame is flagged and frozen
        if (cnt == CNT_MAX) ovf <= 1'b1;
        else begin
          cnt <= cnt + 1'b1;
          sum <= sum + SUM_BITS'(in_data);
          if (cnt == CNT_NEAR) ovf <= 1'b1;
        end
      end
    end
  end

  // threshold products scaled by pixel count, so no divide is needed
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      lo <= '0; hi <= '0;
    end else if (state == EVAL) begin
      lo <= SUM_BITS'(snap_cnt) * SUM_BITS'(LOW_TH);
      hi <= SUM_BITS'(snap_cnt) * SUM_BITS'(HIGH_TH);
    end
  end

  // raw decision; equality at either threshold falls through to 00
  always_comb begin
    raw = 2'b00;
    if (snap_cnt == '0 || snap_ovf) raw = 2'b10;
    else if (snap_sum < lo)         raw = 2'b11;
    else if (snap_sum > hi)         raw = 2'b01;
  end

`ifdef ISP_AE_HYST_EN
  logic [1:0] prev_raw;

  // steer codes (01/11) need agreement with the previous evaluated decision
  always_comb begin
    dec = raw;
    if (raw[0] && raw != prev_raw) dec = 2'b00;
  end

  // remember the raw decision of each evaluated frame
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) prev_raw <= 2'b00;
    else if (state == CMP && !snap_skip) prev_raw <= raw;
  end
`else
  assign dec = raw;
`endif

  // decision register; skipped frames leave it untouched
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      dec_q   <= 2'b00;
      dec_vld <= 1'b0;
    end else begin
      dec_vld <= enable && state == CMP && !snap_skip;
      if (state == CMP && !snap_skip) dec_q <= dec;
    end
  end

  // output stage: response holds between strobes
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      ae_response <= 2'b00;
      ae_valid    <= 1'b0;
    end else begin
      ae_valid <= dec_vld & enable;
      if (dec_vld && enable) ae_response <= dec_q;
    end
  end

endmodule

// File: tb/tb_isp_ae_response_gen.sv
// Scoreboard bench for isp_ae_response_gen. Two instances share the stimulus:
// one evaluates every frame, the other every second frame. The reference
// model works on whole frames (pixel count and luma sum) and predicts the
// code and the strobe cycle; monitors pop and compare on every ae_valid.
module tb_isp_ae_response_gen;

  logic       pclk = 1'b0, rst = 1'b1, enable = 1'b0;
  logic       in_vsync = 1'b0, in_href = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic [1:0] resp0, resp1;
  logic       vld0, vld1;

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  isp_ae_response_gen #(.BITS(8), .WIDTH(4), .HEIGHT(4), .LOW_TH(64), .HIGH_TH(192), .SKIP(0)) dut0 (
    .pclk(pclk), .rst(rst), .enable(enable), .in_vsync(in_vsync), .in_href(in_href),
    .in_data(in_data), .ae_response(resp0), .ae_valid(vld0));

  isp_ae_response_gen #(.BITS(8), .WIDTH(4), .HEIGHT(4), .LOW_TH(64), .HIGH_TH(192), .SKIP(1)) dut1 (
    .pclk(pclk), .rst(rst), .enable(enable), .in_vsync(in_vsync), .in_href(in_href),
    .in_data(in_data), .ae_response(resp1), .ae_valid(vld1));

  typedef struct { logic [1:0] r; int cyc; } exp_t;
  exp_t q0[$], q1[$];

  int         checks = 0, errors = 0;
  logic [1:0] last [2] = '{2'b00, 2'b00};
  int         fc   [2] = '{0, 0};
  logic [1:0] prev [2] = '{2'b00, 2'b00};

  // 5-bit pixel counter in the DUT: 31 or more pixels means saturation
  function automatic logic [1:0] raw_dec(input int n, input int sum);
    if (n == 0 || n >= 31) return 2'b10;
    if (sum < n * 64)      return 2'b11;
    if (sum > n * 192)     return 2'b01;
    return 2'b00;
  endfunction

  function automatic int clamp8(input int v);
    return (v < 0) ? 0 : (v > 255) ? 255 : v;
  endfunction

  task automatic model_frame_end(input int n, input int sum, input int at);
    logic [1:0] r, o;
    exp_t e;
    r = raw_dec(n, sum);
    for (int i = 0; i < 2; i++) begin
      if (fc[i] == 0) begin
        o = r;
`ifdef ISP_AE_HYST_EN
        if ((r == 2'b01 || r == 2'b11) && r != prev[i]) o = 2'b00;
        prev[i] = r;
`endif
        e.r = o; e.cyc = at;
        if (i == 0) q0.push_back(e); else q1.push_back(e);
      end
      fc[i] = (fc[i] == i) ? 0 : fc[i] + 1;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      fc[i] = 0; prev[i] = 2'b00; last[i] = 2'b00;
    end
  endtask

  task automatic chk(input string nm, input logic [1:0] got, input logic [1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  // monitor: pop on strobe, otherwise the response must hold
  task automatic mon(input int i, input logic [1:0] r, input logic v);
    exp_t e;
    bit   got;
    checks++;
    if (v) begin
      got = 1'b0;
      if (i == 0 && q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
      if (i == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
      if (!got) begin
        errors++;
        $display("FAIL unexpected_strobe dut%0d: resp=%b cyc=%0d, expected no strobe", i, r, cyc);
      end else begin
        if (r !== e.r || cyc != e.cyc) begin
          errors++;
          $display("FAIL strobe dut%0d: got resp=%b cyc=%0d expected resp=%b cyc=%0d", i, r, cyc, e.r, e.cyc);
        end
        last[i] = e.r;
      end
    end else if (r !== last[i]) begin
      errors++;
      $display("FAIL hold dut%0d: got resp=%b expected %b at cyc=%0d", i, r, last[i], cyc);
    end
  endtask

  always @(negedge pclk) begin
    if (!rst) begin
      mon(0, resp0, vld0);
      mon(1, resp1, vld1);
    end
  end

  // v >= 0: constant pixel value; v < 0: random around a random centre.
  // abort_at >= 0 interrupts the frame after that many pixels (rst or enable drop).
  task automatic send_frame(input int n, input int v, input int abort_at, input bit use_rst);
    int sum, sent, c, p;
    sum = 0; sent = 0;
    c = $urandom_range(0, 255);
    @(negedge pclk);
    in_vsync = 1'b1; in_href = 1'b0;
    repeat (2) @(negedge pclk);
    while (sent < n) begin
      in_href = 1'b1;
      for (int k = 0; k < 4 && sent < n; k++) begin
        p = (v >= 0) ? v : clamp8(c + $urandom_range(0, 60) - 30);
        in_data = 8'(p); sum += p; sent++;
        @(negedge pclk);
        if (sent == abort_at) begin
          if (use_rst) begin
            rst = 1'b1; model_reset();
            @(negedge pclk);
            rst = 1'b0;
          end else begin
            enable = 1'b0;
            @(negedge pclk);
            enable = 1'b1;
          end
        end
      end
      in_href = 1'b0;
      repeat (2) @(negedge pclk);
    end
    in_vsync = 1'b0;
    // sampled low at the next edge (cyc+1); strobe visible after the 3rd edge after that
    if (abort_at < 0) model_frame_end(n, sum, cyc + 4);
    repeat (6) @(negedge pclk);
  endtask

  initial begin
    repeat (3) @(negedge pclk);
    chk("reset_resp0", resp0, 2'b00);
    chk("reset_valid0", {1'b0, vld0}, 2'b00);
    chk("reset_resp1", resp1, 2'b00);
    chk("reset_valid1", {1'b0, vld1}, 2'b00);
    rst = 1'b0;
    repeat (2) @(negedge pclk);
    enable = 1'b1;
    repeat (2) @(negedge pclk);

    // under, under, over, over (also the hysteresis sequence)
    send_frame(16, 32, -1, 1'b0);
    send_frame(16, 32, -1, 1'b0);
    send_frame(16, 224, -1, 1'b0);
    send_frame(16, 224, -1, 1'b0);
    send_frame(16, 128, -1, 1'b0);
    // threshold equality on both sides
    send_frame(16, 64, -1, 1'b0);
    send_frame(16, 192, -1, 1'b0);
    // no pixels, then saturation
    send_frame(0, 0, -1, 1'b0);
    send_frame(40, 100, -1, 1'b0);
    // reset mid-frame: partial frame discarded, skip counters restart
    send_frame(16, 224, 8, 1'b1);
    send_frame(16, 32, -1, 1'b0);
    send_frame(16, 32, -1, 1'b0);
    send_frame(16, 32, -1, 1'b0);
    send_frame(16, 32, -1, 1'b0);
    // enable drop mid-frame: frame discarded, skip counters hold
    send_frame(16, 224, 5, 1'b0);
    send_frame(16, 224, -1, 1'b0);
    send_frame(12, 10, -1, 1'b0);

    for (int f = 0; f < 24; f++)
      send_frame(($urandom_range(0, 7) == 0) ? 40 : int'($urandom_range(0, 16)), -1, -1, 1'b0);

    for (int t = 0; t < 50 && (q0.size() > 0 || q1.size() > 0); t++) @(negedge pclk);
    checks++;
    if (q0.size() > 0 || q1.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d strobes outstanding, expected 0/0", q0.size(), q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
